// File: rtl/keypad_scanner_if.sv
// Key hand-off between the keypad scanner (master) and its consumer (slave).
interface keypad_scanner_if;
  logic [3:0] KeyCode;
  logic       KeyValid;
  logic       KeyAck;
  logic       Overrun;

  modport master (output KeyCode, output KeyValid, output Overrun, input KeyAck);
  modport slave  (input KeyCode, input KeyValid, input Overrun, output KeyAck);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with per-key debounce and a one-deep key hand-off.
// KEYPAD_DIGIT_SHIFT_EN adds a six-digit history register for the display.
//
// state    | meaning
// SCAN     | driving columns in turn, looking for any active row
// DEBOUNCE | column frozen, counting consecutive samples of the captured row
// HELD     | key accepted and emitted, waiting for it to go away
// RELEASE  | counting consecutive clear samples before scanning resumes
module keypad_scanner #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [3:0]  Rows,
  output logic [3:0]  Cols,
  keypad_scanner_if.master key_if,
  output logic [23:0] Digits,
  output logic [5:0]  DigitEnables
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t      state;
  logic [3:0]  rows_meta;
  logic [3:0]  rows_sync;
  logic [15:0] dwell;
  logic [1:0]  col;
  logic [1:0]  row;
  logic [3:0]  count;

  logic        sample;
  logic        row_hit;
  logic        count_done;
  logic        emit;
  logic        accept;
  logic [3:0]  code;
  logic [1:0]  low_row;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      rows_meta <= '0;
      rows_sync <= '0;
    end else begin
      rows_meta <= Rows;
      rows_sync <= rows_meta;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset)
      dwell <= '0;
    else if (sample)
      dwell <= '0;
    else
      dwell <= dwell + 16'd1;
  end

  always_comb begin
    sample     = (dwell == 16'(SCAN_DIV - 1));
    row_hit    = rows_sync[row];
    // count already includes the sample that moved us into DEBOUNCE/RELEASE
    count_done = (({1'b0, count} + 5'd1) >= 5'(DEBOUNCE_CNT));
    emit       = sample && (state == DEBOUNCE) && row_hit && count_done;
    accept     = !key_if.KeyValid || key_if.KeyAck;
    code       = {row, col};
    low_row    = 2'd3;
    if (rows_sync[2]) low_row = 2'd2;
    if (rows_sync[1]) low_row = 2'd1;
    if (rows_sync[0]) low_row = 2'd0;
  end

  assign Cols = 4'b0001 << col;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state           <= SCAN;
      col             <= '0;
      row             <= '0;
      count           <= '0;
      key_if.KeyCode  <= '0;
      key_if.KeyValid <= 1'b0;
      key_if.Overrun  <= 1'b0;
    end else begin
      case (state)
        SCAN: if (sample) begin
          if (|rows_sync) begin
            state <= DEBOUNCE;
            row   <= low_row;
            count <= 4'd1;
          end else begin
            col <= col + 2'd1;
          end
        end
        DEBOUNCE: if (sample) begin
          if (row_hit) begin
            if (count_done) begin
              state <= HELD;
              count <= '0;
            end else begin
              count <= count + 4'd1;
            end
          end else begin
            state <= SCAN;
            count <= '0;
            col   <= col + 2'd1;
          end
        end
        HELD: if (sample && !row_hit) begin
          state <= RELEASE;
          count <= 4'd1;
        end
        RELEASE: if (sample) begin
          if (!row_hit) begin
            if (count_done) begin
              state <= SCAN;
              count <= '0;
              col   <= col + 2'd1;
            end else begin
              count <= count + 4'd1;
            end
          end else begin
            state <= HELD;
            count <= '0;
          end
        end
        default: state <= SCAN;
      endcase

      if (emit) begin
        if (accept) begin
          key_if.KeyCode  <= code;
          key_if.KeyValid <= 1'b1;
          if (key_if.KeyAck && key_if.KeyValid)
            key_if.Overrun <= 1'b0;
        end else begin
          key_if.Overrun <= 1'b1;
        end
      end else if (key_if.KeyAck && key_if.KeyValid) begin
        key_if.KeyValid <= 1'b0;
        key_if.Overrun  <= 1'b0;
      end
    end
  end

`ifdef KEYPAD_DIGIT_SHIFT_EN
  // Dropped keys are still shown: the display reflects what was typed.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Digits       <= '0;
      DigitEnables <= '0;
    end else if (emit) begin
      Digits       <= {Digits[19:0], code};
      DigitEnables <= {DigitEnables[4:0], 1'b1};
    end
  end
`else
  assign Digits       = '0;
  assign DigitEnables = '0;
`endif

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clock cycles each column is driven (dwell); legal range 4..65535.
REQ-002 Parameter DEBOUNCE_CNT, default 4: consecutive matching dwell samples required for press/release; legal range 1..15.
REQ-003 Clock  input  1  system clock; all logic on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Rows  input  4  keypad row lines; 1 = key pressed in row r of the driven column; asynchronous to Clock.
REQ-006 Cols  output  4  one-hot active-high column drive.
REQ-007 KeyCode  output  4  code of the last accepted key, row*4+col.
REQ-008 KeyValid  output  1  KeyCode holds an unconsumed key.
REQ-009 KeyAck  input  1  consumer accepts KeyCode.
REQ-010 Overrun  output  1  sticky: a key was dropped while KeyValid was high.
REQ-011 Digits  output  24  last six accepted codes, newest in [3:0]; feeds the seven-segment Data input.
REQ-012 DigitEnables  output  6  bit i set once digit i holds an entered code; feeds DisplayEnables.

Function
REQ-013 Rows shall pass through a 2-flop synchronizer; all decisions shall use the synchronized value (SR).
REQ-014 A dwell counter shall count 0..SCAN_DIV-1 and wrap; the cycle at SCAN_DIV-1 is the sample point.
REQ-015 Cols shall equal 1<<col, col a 2-bit index advancing 3->0 wraparound only at a sample point in state SCAN, or on DEBOUNCE->SCAN / RELEASE->SCAN.
REQ-016 States: SCAN, DEBOUNCE, HELD, RELEASE; col frozen in DEBOUNCE, HELD, RELEASE.
REQ-017 SCAN: at sample point, SR!=0 -> DEBOUNCE, capture row = lowest set bit of SR, count=1; else advance col.
REQ-018 DEBOUNCE: at sample point, captured row bit set -> count+1; when count reaches DEBOUNCE_CNT -> HELD and emit; bit clear -> SCAN.
REQ-019 DEBOUNCE_CNT=1 shall emit on the first DEBOUNCE sample point, i.e. directly SCAN->DEBOUNCE->HELD within one dwell plus one.
REQ-020 HELD: at sample point, captured row bit clear -> RELEASE, count=1; no repeat emission while held.
REQ-021 RELEASE: at sample point, bit clear -> count+1, reaching DEBOUNCE_CNT -> SCAN; bit set -> HELD, count cleared.
REQ-022 Emit: if KeyValid=0 or KeyAck=1 that cycle, KeyCode<=code and KeyValid<=1 next cycle; else key dropped and Overrun<=1.
REQ-023 KeyAck=1 with KeyValid=1 and no simultaneous emit shall clear KeyValid next cycle; KeyAck with KeyValid=0 ignored.
REQ-024 Overrun shall clear only on the cycle KeyAck=1 and KeyValid=1 and no drop occurs that cycle.
REQ-025 Multiple rows pressed in one column: lowest row index wins; other columns not scanned until RELEASE completes.

Reset
REQ-026 Reset shall force: state SCAN, col=0, Cols=4'b0001, dwell and debounce counters 0, synchronizer 0, KeyCode=0, KeyValid=0, Overrun=0, Digits=0, DigitEnables=0.
REQ-027 Reset mid-debounce or mid-hold shall abort without emission; a still-held key shall be re-detected and emitted after reset.

Configuration
REQ-028 Macro KEYPAD_DIGIT_SHIFT_EN defined: each emission (accepted or dropped) shifts Digits <= {Digits[19:0],code} and DigitEnables <= {DigitEnables[4:0],1'b1}.
REQ-029 Macro KEYPAD_DIGIT_SHIFT_EN undefined: Digits and DigitEnables tied to 0, no shift register synthesized; all other behaviour identical.

Verification
REQ-030 SCAN_DIV=4, no keys: Cols cycles 0001,0010,0100,1000,0001, each for 4 cycles; KeyValid stays 0.
REQ-031 DEBOUNCE_CNT=3, hold row 2 in column 1 -> KeyValid=1, KeyCode=9 exactly once; release and re-press -> second KeyCode=9 after KeyAck.
REQ-032 Row pulse shorter than DEBOUNCE_CNT-1 dwells -> no emission, returns to SCAN, col advances.
REQ-033 Press key 5 then key 3 with no KeyAck -> KeyCode=5, Overrun=1; KeyAck -> KeyValid=0, Overrun=0.
REQ-034 KEYPAD_DIGIT_SHIFT_EN defined, enter keys 1,2,3 -> Digits=24'h000123, DigitEnables=6'b000111; seven keys -> DigitEnables=6'b111111, oldest lost.
REQ-035 Reset asserted during HELD of key 6 -> all outputs reset values next cycle; key still held -> KeyCode=6 re-emitted.
